// File: rtl/usart_pkg.sv
// Shared types and constants for the USART transmitter.
package usart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DATA_BITS        = 8;
   localparam int BYTES_PER_WORD   = 4;
   localparam int DEFAULT_BAUD_DIV = 434;   // 50 MHz / 115200

endpackage

// File: rtl/fifo_palavra.sv
// Word FIFO feeding the transmitter. Holds FIFO_DEPTH 32-bit words, exposes
// registered full/empty flags and a sticky overflow flag for dropped writes.
module fifo_palavra #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        cheio,
   output logic        vazio,
   output logic        estouro
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [31:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_next;
   logic [AW:0] rd_next;
   logic        do_push;
   logic        do_pop;

   // A write into a full FIFO is still accepted when the same edge pops,
   // since a slot frees up at that edge.
   always_comb begin
      do_pop  = pop && !vazio;
      do_push = push && (!cheio || do_pop);
      wr_next = do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_next = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
   end

   // The head word is presented combinationally so the pop edge can load it.
   assign dout = mem[rd_ptr[AW-1:0]];

   // Storage array; no reset needed since flushing is done by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   // Pointers and flags; flags are computed from the next pointers so they
   // are valid right after the edge that changes occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         vazio   <= 1'b1;
         cheio   <= 1'b0;
         estouro <= 1'b0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         vazio  <= (wr_next == rd_next);
         cheio  <= (wr_next == {~rd_next[AW], rd_next[AW-1:0]});
         if (push && cheio && !do_pop) begin
            estouro <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/usart_tx.sv
// 32-bit word serial transmitter: each word goes out as four 8N1 frames,
// least-significant byte first, BAUD_DIV clock cycles per bit.
module usart_tx
   import usart_pkg::*;
#(
   parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dado,
   input  logic        escreve,
   output logic        tx,
   output logic        ocupado,
   output logic        vazio,
   output logic        cheio,
   output logic        estouro
);

   localparam int             BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [1:0]     BYTE_LAST = 2'(BYTES_PER_WORD - 1);

   state_t        state;
   logic [31:0]   shift_reg;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [1:0]    byte_cnt;
   logic          tx_reg;
   logic          ocupado_reg;
   logic          baud_end;
   logic          pop;
   logic [31:0]   head;
   logic          fifo_vazio;

   fifo_palavra #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (escreve),
      .pop     (pop),
      .din     (dado),
      .dout    (head),
      .cheio   (cheio),
      .vazio   (fifo_vazio),
      .estouro (estouro)
   );

   assign baud_end = (baud_cnt == BAUD_LAST);

   // Pop when idle with data waiting, or at the end of the last stop bit of
   // a word so the next word starts with no idle gap.
   always_comb begin
      pop = 1'b0;
      if (state == IDLE && !fifo_vazio) begin
         pop = 1'b1;
      end else if (state == STOP && baud_end && byte_cnt == BYTE_LAST && !fifo_vazio) begin
         pop = 1'b1;
      end
   end

   // Frame sequencer: counters, shift register and registered line outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shift_reg   <= '0;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         tx_reg      <= 1'b1;
         ocupado_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (!fifo_vazio) begin
                  shift_reg   <= head;
                  byte_cnt    <= '0;
                  bit_cnt     <= '0;
                  tx_reg      <= 1'b0;
                  ocupado_reg <= 1'b1;
                  state       <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
                  tx_reg    <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  state     <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     tx_reg <= 1'b1;
                     state  <= STOP;
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     tx_reg    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (byte_cnt != BYTE_LAST) begin
                     byte_cnt <= byte_cnt + 1'b1;
                     tx_reg   <= 1'b0;
                     state    <= START;
                  end else if (!fifo_vazio) begin
                     shift_reg <= head;
                     byte_cnt  <= '0;
                     tx_reg    <= 1'b0;
                     state     <= START;
                  end else begin
                     ocupado_reg <= 1'b0;
                     state       <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign tx      = tx_reg;
   assign ocupado = ocupado_reg;
   assign vazio   = fifo_vazio;

endmodule

// File: tb/tb_usart_tx.sv
// Scoreboard bench for usart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_usart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] dado = '0;
   logic        escreve = 1'b0;
   logic        tx;
   logic        ocupado;
   logic        vazio;
   logic        cheio;
   logic        estouro;

   usart_tx #(
      .BAUD_DIV   (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .dado    (dado),
      .escreve (escreve),
      .tx      (tx),
      .ocupado (ocupado),
      .vazio   (vazio),
      .cheio   (cheio),
      .estouro (estouro)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      bit         gap;   // frame must start exactly 40 cycles after the previous one
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   rst_epoch = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst) rst_epoch = rst_epoch + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic expect_word(input logic [31:0] w, input bit gap_first);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.b   = w[8*i +: 8];
         e.gap = (i != 0) || gap_first;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_reset_values();
      check("rst_tx", tx, 1);
      check("rst_ocupado", ocupado, 0);
      check("rst_vazio", vazio, 1);
      check("rst_cheio", cheio, 0);
      check("rst_estouro", estouro, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(ocupado === 1'b0 && vazio === 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", (n < budget), 1);
      repeat (5) @(negedge clk);
   endtask

   // Monitor: decodes frames from tx and compares them with the scoreboard.
   initial begin : monitor
      logic       tx_prev;
      logic [7:0] data;
      bit         bad;
      int         st;
      int         ep;
      int         last_start;
      exp_t       e;
      tx_prev    = 1'b1;
      last_start = -1000;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tx_prev === 1'b1 && tx === 1'b0) begin
            st  = cyc;
            ep  = rst_epoch;
            bad = 0;
            repeat (2) @(negedge clk);
            if (tx !== 1'b0 || ocupado !== 1'b1) bad = 1;
            for (int b = 0; b < 8; b++) begin
               repeat (4) @(negedge clk);
               data[b] = tx;
               if (ocupado !== 1'b1) bad = 1;
            end
            repeat (4) @(negedge clk);
            if (tx !== 1'b1 || ocupado !== 1'b1) bad = 1;
            if (ep == rst_epoch) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame_unexpected: got byte %h expected no frame", data);
               end else begin
                  e = exp_q.pop_front();
                  if (data !== e.b || bad || (e.gap && st != last_start + 40)) begin
                     errors++;
                     $display("FAIL frame: got byte %h fmt_err=%0d start_gap=%0d expected byte %h fmt_err=0 gap_checked=%0d(40)",
                              data, bad, st - last_start, e.b, e.gap);
                  end else begin
                     $display("ok   frame: byte %h start_gap=%0d", data, st - last_start);
                  end
               end
            end
            last_start = st;
         end
         tx_prev = tx;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      int bad;
      logic [31:0] w [6];

      // Reset state
      repeat (2) @(negedge clk);
      do_reset();

      // 1. Single word
      escreve = 1'b1;
      dado    = 32'hA5C3_0F81;
      expect_word(32'hA5C3_0F81, 0);
      @(negedge clk);
      escreve = 1'b0;
      check("s1_vazio_after_write", vazio, 0);
      check("s1_tx_still_idle", tx, 1);
      @(negedge clk);
      check("s1_start_bit", tx, 0);
      check("s1_ocupado_rises", ocupado, 1);
      check("s1_vazio_after_pop", vazio, 1);
      n = 0;
      while (ocupado === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      check("s1_busy_cycles", n, 160);
      check("s1_tx_idle_after", tx, 1);
      wait_idle(50);

      // 2. Back-to-back words
      escreve = 1'b1;
      dado    = 32'h0000_0001;
      expect_word(32'h0000_0001, 0);
      expect_word(32'hFFFF_FFFF, 1);
      @(negedge clk);
      dado = 32'hFFFF_FFFF;
      @(negedge clk);
      escreve = 1'b0;
      check("s2_vazio_second_queued", vazio, 0);
      repeat (159) @(negedge clk);
      check("s2_vazio_before_pop", vazio, 0);
      @(negedge clk);
      check("s2_vazio_after_pop", vazio, 1);
      check("s2_ocupado_no_gap", ocupado, 1);
      wait_idle(400);

      // 3. Overflow: six writes while idle, the sixth is dropped
      for (int k = 0; k < 6; k++) begin
         w[k] = 32'h0302_0100 + 32'h0404_0404 * k;
      end
      for (int k = 0; k < 5; k++) expect_word(w[k], (k != 0));
      for (int k = 0; k < 6; k++) begin
         escreve = 1'b1;
         dado    = w[k];
         @(negedge clk);
         if (k == 4) begin
            check("s3_cheio_after_5th", cheio, 1);
            check("s3_estouro_before_drop", estouro, 0);
         end
      end
      escreve = 1'b0;
      check("s3_estouro_after_drop", estouro, 1);
      check("s3_cheio_after_drop", cheio, 1);
      wait_idle(1200);
      check("s3_estouro_sticky", estouro, 1);

      do_reset();

      // 4. Write and pop on the same edge while full
      for (int k = 0; k < 6; k++) expect_word(w[k], (k != 0));
      for (int k = 0; k < 5; k++) begin
         escreve = 1'b1;
         dado    = w[k];
         @(negedge clk);
      end
      escreve = 1'b0;
      check("s4_cheio_filled", cheio, 1);
      repeat (156) @(negedge clk);
      check("s4_cheio_before_pop", cheio, 1);
      escreve = 1'b1;
      dado    = w[5];
      @(negedge clk);
      escreve = 1'b0;
      check("s4_cheio_kept", cheio, 1);
      check("s4_estouro_clear", estouro, 0);
      wait_idle(1200);
      check("s4_estouro_final", estouro, 0);

      // 5. Reset mid-frame (DATA bit 3 of byte 1)
      escreve = 1'b1;
      dado    = 32'h1234_5678;
      begin
         exp_t e;
         e.b   = 8'h78;
         e.gap = 0;
         exp_q.push_back(e);
      end
      @(negedge clk);
      escreve = 1'b0;
      repeat (59) @(negedge clk);
      check("s5_tx_bit3_of_56", tx, 0);
      check("s5_ocupado_mid", ocupado, 1);
      #2 rst = 1'b0;
      #1;
      check("s5_async_tx", tx, 1);
      check("s5_async_ocupado", ocupado, 0);
      check("s5_async_vazio", vazio, 1);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || ocupado !== 1'b0) bad++;
      end
      check("s5_silent_after_reset", bad, 0);
      check("s5_vazio_after_reset", vazio, 1);

      // 6. Strobe low with data toggling
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         dado = $urandom;
         @(negedge clk);
         if (tx !== 1'b1 || vazio !== 1'b1) bad++;
      end
      check("s6_no_activity", bad, 0);

      repeat (10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
